mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single pulse-request memory port between two requesters: port C (the cpu core) and port D (a debug/DMA loader).
- Each requester issues one-cycle rd_en/wr_en pulses and waits for rd_valid, exactly as it would against bare memory.
- The arbiter buffers one request per port, arbitrates, drives the downstream memory and routes read data back to the issuing port.

Parameters:
- ADDR_W, 16, address width on all ports.
- DATA_W, 32, data width on all ports.
- RR, 1, 1 = round-robin between C and D on contention; 0 = fixed priority, C wins.
- TIMEOUT_CYC, 255, read-wait cycles before forced completion (used only with MEM_ARB_TIMEOUT_EN).

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- c_rd_en / d_rd_en  in  1  read request pulse, port C / D
- c_wr_en / d_wr_en  in  1  write request pulse, port C / D
- c_addr / d_addr  in  ADDR_W  request address, sampled with the pulse
- c_wr_data / d_wr_data  in  DATA_W  write data, sampled with the pulse
- c_rd_data / d_rd_data  out  DATA_W  read data, valid with the matching rd_valid
- c_rd_valid / d_rd_valid  out  1  one-cycle read-completion pulse
- mem_rd_en  out  1  downstream read pulse
- mem_wr_en  out  1  downstream write pulse
- mem_addr  out  ADDR_W  downstream address
- mem_wr_data  out  DATA_W  downstream write data
- mem_rd_data  in  DATA_W  downstream read data
- mem_rd_valid  in  1  downstream read completion
- overflow  out  2  sticky per-port flag; bit0 = C, bit1 = D
- busy  out  1  high while a read is outstanding downstream

Behaviour:
- Reset (rst_n low at an edge) clears:
  - all outputs to 0 and both pending buffers;
  - state to IDLE, last_grant to D, so C wins the first tie.
- Capture:
  - A rd_en/wr_en pulse at edge T loads that port's pending buffer (kind, addr, data) at T.
  - If rd_en and wr_en are high together: treat as a write, set overflow bit.
  - A pulse while that port's buffer is already pending: ignored, set overflow bit.
  - overflow clears only on reset.
- State IDLE, at each edge with any buffer pending:
  - Select grant: one pending → that port; both pending → RR=1 picks the port != last_grant, RR=0 picks C.
  - Update last_grant and clear the granted buffer.
  - A buffer loaded at edge T is first eligible at T+1. A new pulse and a grant of the same port's old buffer on the same edge: the new request loads into the now-empty buffer, no overflow.
- Write grant:
  - mem_wr_en=1 for exactly one cycle, with mem_addr/mem_wr_data driven from the buffer.
  - Stay IDLE, so back-to-back grants are possible every cycle.
  - No completion signal to the requester.
- Read grant:
  - mem_rd_en=1 for one cycle, mem_addr driven; record the owner port.
  - Go to RD_WAIT, busy=1.
- State RD_WAIT:
  - No new grants; captures into buffers continue.
  - On mem_rd_valid: owner's rd_data <= mem_rd_data and owner's rd_valid=1 for one cycle (registered, the edge after mem_rd_valid is sampled).
  - Then return to IDLE, busy=0.
  - mem_rd_valid arriving in IDLE is ignored.
- Latency:
  - Read: request pulse edge T, mem_rd_en high during T+1..T+2 (asserted at edge T+1).
  - Requester rd_valid appears 1 cycle after memory's rd_valid; total = mem latency + 2 cycles.
  - Write: reaches memory 1 cycle after the request.
- mem_addr / mem_wr_data hold their last value when no grant is active.
- Reset mid-read: state returns to IDLE; the late mem_rd_valid is dropped; no rd_valid is issued to either port.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN
- Defined:
  - An 8-bit+ counter (width fits TIMEOUT_CYC) runs in RD_WAIT, cleared on each grant.
  - Reaching TIMEOUT_CYC with no mem_rd_valid: owner gets rd_valid=1 with rd_data=32'hDEADBEEF.
  - Extra sticky output port timeout_err (1 bit) is set, and the state returns to IDLE.
- Undefined:
  - No counter and no timeout_err port.
  - RD_WAIT waits indefinitely.

Test Plan:
- C read pulse addr 0x0080, memory returns 0x12345678 after 2 cycles → mem_rd_en with mem_addr=0x0080 one cycle after the pulse; c_rd_valid with 0x12345678 one cycle after mem_rd_valid; d_rd_valid stays 0.
- C and D read pulses on the same edge, RR=1, D addr 0x0100 → C served first; D issued the cycle after C's read completes; second tie goes to D. Same test with RR=0 → C wins every tie.
- C write 0x4/0xCAFEF00D and D write 0x8/0x0BADBEEF on the same edge → two consecutive mem_wr_en cycles, C first, correct addr/data, busy stays 0.
- D read pending, second D pulse before completion → overflow=2'b10; exactly one D read issued; overflow still set after completion.
- rst_n low for 1 cycle during RD_WAIT, then mem_rd_valid arrives → no c_rd_valid/d_rd_valid; busy=0; a next request is served normally.
- MEM_ARB_TIMEOUT_EN, TIMEOUT_CYC=8, memory never answers → c_rd_valid with 0xDEADBEEF 8 cycles into RD_WAIT, timeout_err=1, then IDLE.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port arbiter onto one pulse-request memory: read grant 1 cycle after capture, completion 1 cycle after mem_rd_valid.
// One pending request per port, excess pulses are dropped and flagged; MEM_ARB_TIMEOUT_EN adds a read-wait timeout.
module mem_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 32,
  parameter int RR          = 1,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              c_rd_en,
  input  logic              c_wr_en,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wr_data,
  output logic [DATA_W-1:0] c_rd_data,
  output logic              c_rd_valid,
  input  logic              d_rd_en,
  input  logic              d_wr_en,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wr_data,
  output logic [DATA_W-1:0] d_rd_data,
  output logic              d_rd_valid,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] mem_rd_data,
  input  logic              mem_rd_valid,
  output logic [1:0]        overflow,
  output logic              busy
`ifdef MEM_ARB_TIMEOUT_EN
  ,
  output logic              timeout_err
`endif
);

  typedef enum logic {IDLE, RD_WAIT} state_t;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_t;

  state_t            state;
  logic [1:0]        pend;
  req_t              req_q [2];
  req_t              new_req [2];
  logic              last_grant;   // 0 = C, 1 = D
  logic              owner;
  logic [1:0]        req_in;
  logic [1:0]        both_in;
  logic              grant_vld;
  logic              gsel;
  logic [1:0]        grant_oh;
  req_t              gnt;
  logic              rd_done;
  logic [DATA_W-1:0] rd_done_dat;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);
  logic [CNT_W-1:0] cnt;
`endif

  always_comb begin
    req_in     = {d_rd_en | d_wr_en, c_rd_en | c_wr_en};
    both_in    = {d_rd_en & d_wr_en, c_rd_en & c_wr_en};
    new_req[0] = '{wr: c_wr_en, addr: c_addr, data: c_wr_data};
    new_req[1] = '{wr: d_wr_en, addr: d_addr, data: d_wr_data};
    grant_vld  = (state == IDLE) && (pend != 2'b00);
    // On a tie round-robin hands the grant to whoever did not win last time.
    if (pend == 2'b11) gsel = (RR != 0) ? ~last_grant : 1'b0;
    else               gsel = pend[1];
    grant_oh    = grant_vld ? (gsel ? 2'b10 : 2'b01) : 2'b00;
    gnt         = req_q[gsel];
    rd_done     = (state == RD_WAIT) && mem_rd_valid;
    rd_done_dat = mem_rd_data;
`ifdef MEM_ARB_TIMEOUT_EN
    if ((state == RD_WAIT) && !mem_rd_valid && (cnt == TO_LAST)) begin
      rd_done     = 1'b1;
      rd_done_dat = DATA_W'(32'hDEADBEEF);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      pend        <= 2'b00;
      req_q[0]    <= '0;
      req_q[1]    <= '0;
      last_grant  <= 1'b1;
      owner       <= 1'b0;
      mem_rd_en   <= 1'b0;
      mem_wr_en   <= 1'b0;
      mem_addr    <= '0;
      mem_wr_data <= '0;
      c_rd_data   <= '0;
      c_rd_valid  <= 1'b0;
      d_rd_data   <= '0;
      d_rd_valid  <= 1'b0;
      overflow    <= 2'b00;
      busy        <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt         <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      mem_rd_en  <= 1'b0;
      mem_wr_en  <= 1'b0;
      c_rd_valid <= 1'b0;
      d_rd_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (grant_vld) begin
            last_grant  <= gsel;
            pend[gsel]  <= 1'b0;
            mem_addr    <= gnt.addr;
            if (gnt.wr) begin
              mem_wr_en   <= 1'b1;
              mem_wr_data <= gnt.data;
            end else begin
              mem_rd_en <= 1'b1;
              owner     <= gsel;
              busy      <= 1'b1;
              state     <= RD_WAIT;
`ifdef MEM_ARB_TIMEOUT_EN
              cnt       <= '0;
`endif
            end
          end
        end
        RD_WAIT: begin
          if (rd_done) begin
            if (owner) begin
              d_rd_valid <= 1'b1;
              d_rd_data  <= rd_done_dat;
            end else begin
              c_rd_valid <= 1'b1;
              c_rd_data  <= rd_done_dat;
            end
            busy  <= 1'b0;
            state <= IDLE;
`ifdef MEM_ARB_TIMEOUT_EN
            if (!mem_rd_valid) timeout_err <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
`endif
          end
        end
        default: state <= IDLE;
      endcase

      // Capture runs after the grant so a buffer freed this edge can be refilled this edge.
      for (int p = 0; p < 2; p++) begin
        if (req_in[p]) begin
          if (!pend[p] || grant_oh[p]) begin
            pend[p]  <= 1'b1;
            req_q[p] <= new_req[p];
          end else begin
            overflow[p] <= 1'b1;
          end
          if (both_in[p]) overflow[p] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a vector table for single-port traffic plus sequences for ties, reset and timeout.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        c_rd_en, c_wr_en, d_rd_en, d_wr_en;
  logic [15:0] c_addr, d_addr;
  logic [31:0] c_wr_data, d_wr_data;
  logic [31:0] mem_rd_data;
  logic        mem_rd_valid;

  logic [31:0] rr_c_rd_data, rr_d_rd_data, fp_c_rd_data, fp_d_rd_data;
  logic        rr_c_rd_valid, rr_d_rd_valid, fp_c_rd_valid, fp_d_rd_valid;
  logic        rr_mem_rd_en, rr_mem_wr_en, fp_mem_rd_en, fp_mem_wr_en;
  logic [15:0] rr_mem_addr, fp_mem_addr;
  logic [31:0] rr_mem_wr_data, fp_mem_wr_data;
  logic [1:0]  rr_overflow, fp_overflow;
  logic        rr_busy, fp_busy;
`ifdef MEM_ARB_TIMEOUT_EN
  logic        rr_timeout_err, fp_timeout_err;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(16), .DATA_W(32), .RR(1), .TIMEOUT_CYC(8)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .c_rd_en(c_rd_en), .c_wr_en(c_wr_en), .c_addr(c_addr), .c_wr_data(c_wr_data),
    .c_rd_data(rr_c_rd_data), .c_rd_valid(rr_c_rd_valid),
    .d_rd_en(d_rd_en), .d_wr_en(d_wr_en), .d_addr(d_addr), .d_wr_data(d_wr_data),
    .d_rd_data(rr_d_rd_data), .d_rd_valid(rr_d_rd_valid),
    .mem_rd_en(rr_mem_rd_en), .mem_wr_en(rr_mem_wr_en), .mem_addr(rr_mem_addr),
    .mem_wr_data(rr_mem_wr_data), .mem_rd_data(mem_rd_data), .mem_rd_valid(mem_rd_valid),
    .overflow(rr_overflow), .busy(rr_busy)
`ifdef MEM_ARB_TIMEOUT_EN
    , .timeout_err(rr_timeout_err)
`endif
  );

  mem_arbiter #(.ADDR_W(16), .DATA_W(32), .RR(0), .TIMEOUT_CYC(8)) u_fp (
    .clk(clk), .rst_n(rst_n),
    .c_rd_en(c_rd_en), .c_wr_en(c_wr_en), .c_addr(c_addr), .c_wr_data(c_wr_data),
    .c_rd_data(fp_c_rd_data), .c_rd_valid(fp_c_rd_valid),
    .d_rd_en(d_rd_en), .d_wr_en(d_wr_en), .d_addr(d_addr), .d_wr_data(d_wr_data),
    .d_rd_data(fp_d_rd_data), .d_rd_valid(fp_d_rd_valid),
    .mem_rd_en(fp_mem_rd_en), .mem_wr_en(fp_mem_wr_en), .mem_addr(fp_mem_addr),
    .mem_wr_data(fp_mem_wr_data), .mem_rd_data(mem_rd_data), .mem_rd_valid(mem_rd_valid),
    .overflow(fp_overflow), .busy(fp_busy)
`ifdef MEM_ARB_TIMEOUT_EN
    , .timeout_err(fp_timeout_err)
`endif
  );

  typedef struct {
    logic [3:0]  req;     // {c_rd, c_wr, d_rd, d_wr}
    logic [15:0] ca, da;
    logic [31:0] cw, dw;
    logic        mv;
    logic [31:0] md;
    logic [1:0]  e_en;    // {mem_rd_en, mem_wr_en}
    logic [15:0] e_ma;
    logic [31:0] e_mw;
    logic [1:0]  e_v;     // {c_rd_valid, d_rd_valid}
    logic [31:0] e_cd, e_dd;
    logic [1:0]  e_ovf;
    logic        e_busy;
  } vec_t;

  vec_t vt [21];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_in();
    c_rd_en = 1'b0; c_wr_en = 1'b0; d_rd_en = 1'b0; d_wr_en = 1'b0;
    c_addr = '0; d_addr = '0; c_wr_data = '0; d_wr_data = '0;
    mem_rd_valid = 1'b0; mem_rd_data = '0;
  endtask

  initial begin
    // Writes tie (C first), read in IDLE ignored, simple C read, overflow during RD_WAIT, rd+wr together.
    vt[0]  = '{4'b0101, 16'h0004, 16'h0008, 32'hCAFEF00D, 32'h0BADBEEF, 1'b0, 32'h0, 2'b00, 16'h0000, 32'h00000000, 2'b00, 32'h0, 32'h0, 2'b00, 1'b0};
    vt[1]  = '{4'b0000, 16'h0, 16'h0, 32'h0, 32'h0, 1'b0, 32'h0, 2'b01, 16'h0004, 32'hCAFEF00D, 2'b00, 32'h0, 32'h0, 2'b00, 1'b0};
    vt[2]  = '{4'b0000, 16'h0, 16'h0, 32'h0, 32'h0, 1'b0, 32'h0, 2'b01, 16'h0008, 32'h0BADBEEF, 2'b00, 32'h0, 32'h0, 2'b00, 1'b0};
    vt[3]  = '{4'b0000, 16'h0, 16'h0, 32'h0, 32'h0, 1'b0, 32'h0, 2'b00, 16'h0008, 32'h0BADBEEF, 2'b00, 32'h0, 32'h0, 2'b00, 1'b0};
    vt[4]  = '{4'b0000, 16'h0, 16'h0, 32'h0, 32'h0, 1'b1, 32'h00000099, 2'b00, 16'h0008, 32'h0BADBEEF, 2'b00, 32'h0, 32'h0, 2'b00, 1'b0};
    vt[5]  = '{4'b1000, 16'h0080, 16'h0, 32'h0, 32'h0, 1'b0, 32'h0, 2'b00, 16'h0008, 32'h0BADBEEF, 2'b00, 32'h0, 32'h0, 2'b00, 1'b0};
    vt[6]  = '{4'b0000, 16'h0, 16'h0, 32'h0, 32'h0, 1'b0, 32'h0, 2'b10, 16'h0080, 32'h0BADBEEF, 2'b00, 32'h0, 32'h0, 2'b00, 1'b1};
    vt[7]  = '{4'b0000, 16'h0, 16'h0, 32'h0, 32'h0, 1'b0, 32'h0, 2'b00, 16'h0080, 32'h0BADBEEF, 2'b00, 32'h0, 32'h0, 2'b00, 1'b1};
    vt[8]  = '{4'b0000, 16'h0, 16'h0, 32'h0, 32'h0, 1'b1, 32'h12345678, 2'b00, 16'h0080, 32'h0BADBEEF, 2'b10, 32'h12345678, 32'h0, 2'b00, 1'b0};
    vt[9]  = '{4'b0000, 16'h0, 16'h0, 32'h0, 32'h0, 1'b0, 32'h0, 2'b00, 16'h0080, 32'h0BADBEEF, 2'b00, 32'h12345678, 32'h0, 2'b00, 1'b0};
    vt[10] = '{4'b1000, 16'h0200, 16'h0, 32'h0, 32'h0, 1'b0, 32'h0, 2'b00, 16'h0080, 32'h0BADBEEF, 2'b00, 32'h12345678, 32'h0, 2'b00, 1'b0};
    vt[11] = '{4'b0010, 16'h0, 16'h0100, 32'h0, 32'h0, 1'b0, 32'h0, 2'b10, 16'h0200, 32'h0BADBEEF, 2'b00, 32'h12345678, 32'h0, 2'b00, 1'b1};
    vt[12] = '{4'b0010, 16'h0, 16'h0140, 32'h0, 32'h0, 1'b0, 32'h0, 2'b00, 16'h0200, 32'h0BADBEEF, 2'b00, 32'h12345678, 32'h0, 2'b10, 1'b1};
    vt[13] = '{4'b0000, 16'h0, 16'h0, 32'h0, 32'h0, 1'b1, 32'hAAAA5555, 2'b00, 16'h0200, 32'h0BADBEEF, 2'b10, 32'hAAAA5555, 32'h0, 2'b10, 1'b0};
    vt[14] = '{4'b0000, 16'h0, 16'h0, 32'h0, 32'h0, 1'b0, 32'h0, 2'b10, 16'h0100, 32'h0BADBEEF, 2'b00, 32'hAAAA5555, 32'h0, 2'b10, 1'b1};
    vt[15] = '{4'b0000, 16'h0, 16'h0, 32'h0, 32'h0, 1'b0, 32'h0, 2'b00, 16'h0100, 32'h0BADBEEF, 2'b00, 32'hAAAA5555, 32'h0, 2'b10, 1'b1};
    vt[16] = '{4'b0000, 16'h0, 16'h0, 32'h0, 32'h0, 1'b1, 32'h55AA00FF, 2'b00, 16'h0100, 32'h0BADBEEF, 2'b01, 32'hAAAA5555, 32'h55AA00FF, 2'b10, 1'b0};
    vt[17] = '{4'b0000, 16'h0, 16'h0, 32'h0, 32'h0, 1'b0, 32'h0, 2'b00, 16'h0100, 32'h0BADBEEF, 2'b00, 32'hAAAA5555, 32'h55AA00FF, 2'b10, 1'b0};
    vt[18] = '{4'b0000, 16'h0, 16'h0, 32'h0, 32'h0, 1'b0, 32'h0, 2'b00, 16'h0100, 32'h0BADBEEF, 2'b00, 32'hAAAA5555, 32'h55AA00FF, 2'b10, 1'b0};
    vt[19] = '{4'b1100, 16'h0010, 16'h0, 32'h11112222, 32'h0, 1'b0, 32'h0, 2'b00, 16'h0100, 32'h0BADBEEF, 2'b00, 32'hAAAA5555, 32'h55AA00FF, 2'b11, 1'b0};
    vt[20] = '{4'b0000, 16'h0, 16'h0, 32'h0, 32'h0, 1'b0, 32'h0, 2'b01, 16'h0010, 32'h11112222, 2'b00, 32'hAAAA5555, 32'h55AA00FF, 2'b11, 1'b0};

    idle_in();
    rst_n = 1'b0;
    step();
    step();
    chk("reset mem_rd_en", 32'(rr_mem_rd_en), 32'd0);
    chk("reset mem_wr_en", 32'(rr_mem_wr_en), 32'd0);
    chk("reset mem_addr", 32'(rr_mem_addr), 32'd0);
    chk("reset c_rd_valid", 32'(rr_c_rd_valid), 32'd0);
    chk("reset d_rd_data", rr_d_rd_data, 32'd0);
    chk("reset overflow", 32'(rr_overflow), 32'd0);
    chk("reset busy", 32'(rr_busy), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      {c_rd_en, c_wr_en, d_rd_en, d_wr_en} = vt[i].req;
      c_addr = vt[i].ca; d_addr = vt[i].da;
      c_wr_data = vt[i].cw; d_wr_data = vt[i].dw;
      mem_rd_valid = vt[i].mv; mem_rd_data = vt[i].md;
      step();
      chk($sformatf("v%0d mem_rd_en", i), 32'(rr_mem_rd_en), 32'(vt[i].e_en[1]));
      chk($sformatf("v%0d mem_wr_en", i), 32'(rr_mem_wr_en), 32'(vt[i].e_en[0]));
      chk($sformatf("v%0d mem_addr", i), 32'(rr_mem_addr), 32'(vt[i].e_ma));
      chk($sformatf("v%0d mem_wr_data", i), rr_mem_wr_data, vt[i].e_mw);
      chk($sformatf("v%0d c_rd_valid", i), 32'(rr_c_rd_valid), 32'(vt[i].e_v[1]));
      chk($sformatf("v%0d d_rd_valid", i), 32'(rr_d_rd_valid), 32'(vt[i].e_v[0]));
      chk($sformatf("v%0d c_rd_data", i), rr_c_rd_data, vt[i].e_cd);
      chk($sformatf("v%0d d_rd_data", i), rr_d_rd_data, vt[i].e_dd);
      chk($sformatf("v%0d overflow", i), 32'(rr_overflow), 32'(vt[i].e_ovf));
      chk($sformatf("v%0d busy", i), 32'(rr_busy), 32'(vt[i].e_busy));
    end
    idle_in();
    step();

    // Reset while a read is outstanding; the late completion must be dropped.
    c_rd_en = 1'b1; c_addr = 16'h0300;
    step(); idle_in();
    step();
    chk("rst-mid busy before", 32'(rr_busy), 32'd1);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rst-mid busy", 32'(rr_busy), 32'd0);
    chk("rst-mid overflow", 32'(rr_overflow), 32'd0);
    mem_rd_valid = 1'b1; mem_rd_data = 32'h00000077;
    step(); idle_in();
    chk("rst-mid late c_rd_valid", 32'(rr_c_rd_valid), 32'd0);
    chk("rst-mid late d_rd_valid", 32'(rr_d_rd_valid), 32'd0);
    chk("rst-mid late c_rd_data", rr_c_rd_data, 32'd0);
    step();
    chk("rst-mid idle mem_rd_en", 32'(rr_mem_rd_en), 32'd0);
    d_rd_en = 1'b1; d_addr = 16'h0400;
    step(); idle_in();
    step();
    chk("post-rst mem_rd_en", 32'(rr_mem_rd_en), 32'd1);
    chk("post-rst mem_addr", 32'(rr_mem_addr), 32'h0400);
    step();
    mem_rd_valid = 1'b1; mem_rd_data = 32'hBEEF0001;
    step(); idle_in();
    chk("post-rst d_rd_valid", 32'(rr_d_rd_valid), 32'd1);
    chk("post-rst d_rd_data", rr_d_rd_data, 32'hBEEF0001);
    chk("post-rst c_rd_valid", 32'(rr_c_rd_valid), 32'd0);
    chk("post-rst busy", 32'(rr_busy), 32'd0);
    step();

    // Read ties: RR alternates winners, fixed priority always picks C.
    c_rd_en = 1'b1; c_addr = 16'h0500; d_rd_en = 1'b1; d_addr = 16'h0100;
    step(); idle_in();
    step();
    chk("tie1 rr mem_addr", 32'(rr_mem_addr), 32'h0500);
    chk("tie1 fp mem_addr", 32'(fp_mem_addr), 32'h0500);
    chk("tie1 rr mem_rd_en", 32'(rr_mem_rd_en), 32'd1);
    step();
    c_rd_en = 1'b1; c_addr = 16'h0600;
    step(); idle_in();
    chk("tie c refill overflow", 32'(rr_overflow), 32'd0);
    chk("tie rd_wait no grant", 32'(rr_mem_rd_en), 32'd0);
    mem_rd_valid = 1'b1; mem_rd_data = 32'h11111111;
    step(); idle_in();
    chk("tie1 rr c_rd_valid", 32'(rr_c_rd_valid), 32'd1);
    chk("tie1 rr c_rd_data", rr_c_rd_data, 32'h11111111);
    chk("tie1 fp c_rd_valid", 32'(fp_c_rd_valid), 32'd1);
    step();
    chk("tie2 rr mem_rd_en", 32'(rr_mem_rd_en), 32'd1);
    chk("tie2 rr mem_addr", 32'(rr_mem_addr), 32'h0100);
    chk("tie2 fp mem_addr", 32'(fp_mem_addr), 32'h0600);
    step();
    mem_rd_valid = 1'b1; mem_rd_data = 32'h22222222;
    step(); idle_in();
    chk("tie2 rr d_rd_valid", 32'(rr_d_rd_valid), 32'd1);
    chk("tie2 rr d_rd_data", rr_d_rd_data, 32'h22222222);
    chk("tie2 fp c_rd_valid", 32'(fp_c_rd_valid), 32'd1);
    chk("tie2 fp c_rd_data", fp_c_rd_data, 32'h22222222);
    step();
    chk("tie3 rr mem_addr", 32'(rr_mem_addr), 32'h0600);
    chk("tie3 fp mem_addr", 32'(fp_mem_addr), 32'h0100);
    step();
    mem_rd_valid = 1'b1; mem_rd_data = 32'h33333333;
    step(); idle_in();
    chk("tie3 rr c_rd_valid", 32'(rr_c_rd_valid), 32'd1);
    chk("tie3 fp d_rd_valid", 32'(fp_d_rd_valid), 32'd1);
    chk("tie3 fp d_rd_data", fp_d_rd_data, 32'h33333333);
    step();

`ifdef MEM_ARB_TIMEOUT_EN
    // Memory never answers: forced completion on the 8th RD_WAIT edge.
    c_rd_en = 1'b1; c_addr = 16'h0700;
    step(); idle_in();
    step();
    chk("to busy", 32'(rr_busy), 32'd1);
    chk("to err before", 32'(rr_timeout_err), 32'd0);
    for (int k = 1; k < 8; k++) begin
      step();
      chk($sformatf("to wait%0d c_rd_valid", k), 32'(rr_c_rd_valid), 32'd0);
    end
    step();
    chk("to c_rd_valid", 32'(rr_c_rd_valid), 32'd1);
    chk("to c_rd_data", rr_c_rd_data, 32'hDEADBEEF);
    chk("to timeout_err", 32'(rr_timeout_err), 32'd1);
    chk("to busy after", 32'(rr_busy), 32'd0);
    step();
    chk("to err sticky", 32'(rr_timeout_err), 32'd1);
    chk("to c_rd_valid pulse", 32'(rr_c_rd_valid), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
